// File: rtl/fabric_arb_pkg.sv
// Shared arbitration helpers for the fabric memory arbiters.
// Round-robin pick and error-flag bit positions.
package fabric_arb_pkg;

  localparam int MAX_PORTS = 32;

  localparam int ERR_EMPTY_DONE = 0;
  localparam int ERR_LOCK_DROP  = 1;

  typedef logic [MAX_PORTS-1:0] port_vec_t;

  // One-hot pick of the first valid port at or after ptr, wrapping at n.
  function automatic port_vec_t rr_pick(
    input port_vec_t valid,
    input int        n,
    input int        ptr
  );
    port_vec_t oh;
    logic      found;
    int        idx;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx]) begin
          oh[idx] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/fabric_id_fifo.sv
// In-order ID FIFO: remembers which requester issued each
// outstanding memory operation so completions can be routed back.
module fabric_id_fifo
  import fabric_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer, count and storage updates.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fabric_store_arbiter.sv
// Shares one memory store port among several store PEs with a
// locking round-robin grant and routes completions back in order.
module fabric_store_arbiter
  import fabric_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 0,
  parameter  int DONE_DEPTH = 4,
  localparam int PW         = DATA_WIDTH + TAG_WIDTH,
  localparam int DONE_PW    = (TAG_WIDTH > 0) ? TAG_WIDTH : 1,
  localparam int IDW        = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  output logic [NUM_PORTS-1:0]    req_ready,
  input  logic [NUM_PORTS*PW-1:0] req_addr,
  input  logic [NUM_PORTS*PW-1:0] req_data,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [PW-1:0]           mem_addr,
  output logic [PW-1:0]           mem_data,
  input  logic                    mem_done_valid,
  output logic                    mem_done_ready,
  input  logic [DONE_PW-1:0]      mem_done_data,
  output logic [NUM_PORTS-1:0]    done_valid,
  input  logic [NUM_PORTS-1:0]    done_ready,
  output logic [DONE_PW-1:0]      done_data,
  output logic [1:0]              err
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] locked_id_q, locked_id_d;
  logic           lock_q, lock_d;
  logic [1:0]     err_q, err_d;
  logic [IDW-1:0] grant, head;
  logic           cand_valid, full, empty, fire, pop;
  port_vec_t      vpad, pick;

  // Grant selection: locked port wins, else round-robin scan.
  always_comb begin
    vpad                 = '0;
    vpad[NUM_PORTS-1:0]  = req_valid;
    pick                 = rr_pick(vpad, NUM_PORTS, int'(rr_ptr_q));
    grant                = '0;
    cand_valid           = 1'b0;
    if (lock_q) begin
      grant      = locked_id_q;
      cand_valid = req_valid[locked_id_q];
    end else begin
      for (int i = 0; i < MAX_PORTS; i++) begin
        if (pick[i]) begin
          grant      = IDW'(i);
          cand_valid = 1'b1;
        end
      end
    end
  end

  assign mem_valid = !rst && cand_valid && !full;
  assign fire      = mem_valid && mem_ready;
  assign mem_addr  = req_addr[int'(grant)*PW +: PW];
  assign mem_data  = req_data[int'(grant)*PW +: PW];

  assign mem_done_ready = !rst && !empty && done_ready[head];
  assign pop            = mem_done_valid && mem_done_ready;
  assign done_data      = mem_done_data;
  assign err            = err_q;

  // Per-port accept and completion demux.
  always_comb begin
    req_ready  = '0;
    done_valid = '0;
    if (fire) req_ready[grant] = 1'b1;
    if (!rst && mem_done_valid && !empty) done_valid[head] = 1'b1;
  end

  // Pointer, lock and sticky error next state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    err_d       = err_q;
    if (fire) begin
      rr_ptr_d = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (mem_valid) begin
      lock_d      = 1'b1;
      locked_id_d = grant;
    end
    if (lock_q && !req_valid[locked_id_q]) err_d[ERR_LOCK_DROP] = 1'b1;
    if (mem_done_valid && empty) err_d[ERR_EMPTY_DONE] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      locked_id_q <= '0;
      lock_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      locked_id_q <= locked_id_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  fabric_id_fifo #(
    .WIDTH(IDW),
    .DEPTH(DONE_DEPTH)
  ) u_id_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fire),
    .din  (grant),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

endmodule

// File: tb/tb_fabric_store_arbiter.sv
// Bench for fabric_store_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_fabric_store_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int PW    = DW + TW;
  localparam int DPW   = TW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*PW-1:0] req_addr = '0;
  logic [N*PW-1:0] req_data = '0;
  logic           mem_valid;
  logic           mem_ready = 1'b0;
  logic [PW-1:0]  mem_addr, mem_data;
  logic           mem_done_valid = 1'b0;
  logic           mem_done_ready;
  logic [DPW-1:0] mem_done_data = '0;
  logic [N-1:0]   done_valid;
  logic [N-1:0]   done_ready = '0;
  logic [DPW-1:0] done_data;
  logic [1:0]     err;

  int n_chk = 0;
  int n_err = 0;

  fabric_store_arbiter #(
    .NUM_PORTS (N),
    .DATA_WIDTH(DW),
    .TAG_WIDTH (TW),
    .DONE_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_done_valid(mem_done_valid),
    .mem_done_ready(mem_done_ready),
    .mem_done_data (mem_done_data),
    .done_valid    (done_valid),
    .done_ready    (done_ready),
    .done_data     (done_data),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_rr = 0, m_lid = 0;
  bit       m_lock = 0;
  bit [1:0] m_err = 0;
  int       q[$];
  int       n_rr, n_lid;
  bit       n_lock;
  bit [1:0] n_err2;
  int       nq[$];

  function automatic logic [PW-1:0] port_addr(input int p);
    return req_addr[p*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] port_data(input int p);
    return req_data[p*PW +: PW];
  endfunction

  always @(negedge clk) begin
    int g, head;
    bit v, full, empty, e_mv, fire, e_mdr, dv;
    logic [N-1:0] e_rr, e_dv;
    if (rst) begin
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_mem_done_ready", mem_done_ready, 0);
      chk("rst_err", err, 0);
      n_rr = 0; n_lid = 0; n_lock = 0; n_err2 = 0;
      nq = {};
      m_err = 0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      v = 0; g = 0;
      if (m_lock) begin
        g = m_lid;
        v = req_valid[g];
      end else begin
        for (int i = 0; i < N; i++) begin
          int p;
          p = (m_rr + i) % N;
          if (!v && req_valid[p]) begin v = 1; g = p; end
        end
      end
      e_mv  = v && !full;
      fire  = e_mv && mem_ready;
      e_rr  = fire ? N'(1 << g) : '0;
      head  = empty ? 0 : q[0];
      dv    = mem_done_valid && !empty;
      e_dv  = dv ? N'(1 << head) : '0;
      e_mdr = !empty && done_ready[head];
      chk("mem_valid", mem_valid, e_mv);
      chk("req_ready", req_ready, e_rr);
      chk("done_valid", done_valid, e_dv);
      chk("mem_done_ready", mem_done_ready, e_mdr);
      chk("err", err, m_err);
      if (e_mv) begin
        chk("mem_addr", mem_addr, port_addr(g));
        chk("mem_data", mem_data, port_data(g));
      end
      if (dv) chk("done_data", done_data, mem_done_data);
      nq = q;
      if (mem_done_valid && e_mdr) void'(nq.pop_front());
      n_rr = m_rr; n_lock = m_lock; n_lid = m_lid; n_err2 = m_err;
      if (fire) begin
        nq.push_back(g);
        n_rr   = (g + 1) % N;
        n_lock = 0;
      end else if (e_mv) begin
        n_lock = 1;
        n_lid  = g;
      end
      if (m_lock && !req_valid[m_lid]) n_err2[1] = 1;
      if (mem_done_valid && empty) n_err2[0] = 1;
    end
  end

  always @(posedge clk) begin
    m_rr = n_rr; m_lid = n_lid; m_lock = n_lock; m_err = n_err2;
    q = nq;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    req_valid = '0; mem_ready = 0; mem_done_valid = 0;
    done_ready = '0; mem_done_data = '0;
  endtask

  task automatic set_payload(input bit rnd);
    for (int p = 0; p < N; p++) begin
      if (rnd) begin
        req_addr[p*PW +: PW] = PW'({$urandom, $urandom});
        req_data[p*PW +: PW] = PW'({$urandom, $urandom});
      end else begin
        req_addr[p*PW +: PW] = PW'(36'hA_0000_0100 + p);
        req_data[p*PW +: PW] = PW'(36'h5_0000_0D00 + p);
      end
    end
  endtask

  initial begin
    idle();
    set_payload(0);
    req_valid = 4'hF; mem_ready = 1;
    settle();
    chk("s1_reset_mem_valid", mem_valid, 0);
    tick(); tick();
    rst = 0;
    // all valid, memory always ready: 0,1,2,3
    for (int k = 0; k < N; k++) begin
      settle();
      chk("s2_grant_seq", req_ready, 1 << k);
      if (k == 0) chk("s2_addr0", mem_addr, 36'hA_0000_0100);
      tick();
    end
    // FIFO full: no issue even with a pop this cycle
    mem_done_valid = 1; done_ready = 4'hF;
    settle();
    chk("s4_full_block", mem_valid, 0);
    chk("s4_done_port0", done_valid, 4'b0001);
    chk("s4_pop_ready", mem_done_ready, 1);
    tick();
    mem_done_valid = 0;
    settle();
    chk("s4_issue_after_pop", req_ready, 4'b0001);
    tick();
    // drain: FIFO order 1,2,3,0
    req_valid = 0; mem_ready = 0; mem_done_valid = 1;
    for (int k = 0; k < N; k++) begin
      settle();
      chk("s2_fifo_order", done_valid, 1 << ((k + 1) % N));
      tick();
    end
    mem_done_valid = 0;
    // stall on port 2 for 3 cycles, port 1 joining must not steal
    req_valid = 4'b1100; mem_ready = 0;
    settle();
    chk("s3_stall_addr", mem_addr, 36'hA_0000_0102);
    chk("s3_stall_ready", req_ready, 0);
    tick();
    req_valid = 4'b1110;
    repeat (2) begin
      settle();
      chk("s3_locked_addr", mem_addr, 36'hA_0000_0102);
      chk("s3_locked_ready", req_ready, 0);
      tick();
    end
    mem_ready = 1;
    settle();
    chk("s3_fire_port2", req_ready, 4'b0100);
    tick();
    settle();
    chk("s3_next_port3", req_ready, 4'b1000);
    tick();
    req_valid = 0; mem_ready = 0;
    mem_done_valid = 1; done_ready = 4'hF;
    tick(); tick();
    mem_done_valid = 0; done_ready = 0;
    // stores from 1 then 3, back-pressured done
    req_valid = 4'b0010; mem_ready = 1;
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = 0; mem_ready = 0;
    mem_done_valid = 1; mem_done_data = 4'h5;
    repeat (2) begin
      settle();
      chk("s5_hold_ready", mem_done_ready, 0);
      chk("s5_hold_valid", done_valid, 4'b0010);
      chk("s5_hold_data", done_data, 4'h5);
      tick();
    end
    done_ready = 4'b0010;
    settle();
    chk("s5_pop_ready", mem_done_ready, 1);
    tick();
    mem_done_data = 4'hA; done_ready = 4'hF;
    settle();
    chk("s5_next_port3", done_valid, 4'b1000);
    tick();
    // done with empty FIFO
    settle();
    chk("s6_empty_ready", mem_done_ready, 0);
    chk("s6_empty_valid", done_valid, 0);
    tick();
    mem_done_valid = 0;
    settle();
    chk("s6_err0_set", err, 2'b01);
    tick(); tick();
    settle();
    chk("s6_err0_sticky", err, 2'b01);
    tick();
    // locked requester drops valid
    req_valid = 4'b0001; mem_ready = 0;
    tick();
    req_valid = 0;
    tick();
    req_valid = 4'b0010;
    settle();
    chk("lock_drop_err", err, 2'b11);
    chk("lock_hold_port0", mem_valid, 0);
    tick();
    req_valid = 4'b0001; mem_ready = 1;
    settle();
    chk("lock_resume", req_ready, 4'b0001);
    tick();
    idle();
    // randomized traffic, occasional mid-traffic reset
    for (int c = 0; c < 3000; c++) begin
      set_payload(1);
      req_valid      = N'($urandom);
      mem_ready      = ($urandom_range(0, 3) != 0);
      mem_done_valid = ($urandom_range(0, 2) == 0);
      done_ready     = N'($urandom);
      mem_done_data  = DPW'($urandom);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    set_payload(0);
    req_valid = 4'hF; mem_ready = 1; mem_done_valid = 0;
    tick(); tick();
    rst = 1;
    settle();
    chk("s1_mid_reset_err", err, 0);
    chk("s1_mid_reset_valid", mem_valid, 0);
    tick();
    rst = 0;
    settle();
    chk("s1_first_grant", req_ready, 4'b0001);
    tick();
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
